// File: rtl/fpdsp_issue_seq.sv
// Host-side issue sequencer for the iterative FP DSP core: launches one operation
// at a time, waits for completion or watchdog expiry, and queues tagged responses.
module fpdsp_issue_seq #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64,
  parameter int MIN_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [1:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      core_a,
  output logic [31:0]      core_b,
  output logic [1:0]       core_op,
  output logic             core_run,
  input  logic [31:0]      core_result,
  input  logic [4:0]       core_flags,
  input  logic             core_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [4:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends on ready, and a presented response holds until taken.

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag_q;

  logic [31:0]      buf_result [2];
  logic [4:0]       buf_flags  [2];
  logic [TAG_W-1:0] buf_tag    [2];
  logic             buf_to     [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       buf_count;
  logic [1:0]       count_nxt;

  logic             ready_hit;
  logic             timeout_hit;
  logic             push;
  logic             pop;

  // Ready is only trusted once MIN_LAT cycles of WAIT have passed, masking the
  // previous operation's lingering ready; a real completion beats the watchdog.
  assign ready_hit   = (state == S_WAIT) && (cnt >= CNT_W'(MIN_LAT)) && core_ready;
  assign timeout_hit = (state == S_WAIT) && !ready_hit && (cnt == CNT_W'(TIMEOUT - 1));
  assign push        = ready_hit || timeout_hit;
  assign pop         = rsp_valid && rsp_ready;

  always_comb begin
    count_nxt = buf_count;
    case ({push, pop})
      2'b10:   count_nxt = buf_count + 2'd1;
      2'b01:   count_nxt = buf_count - 2'd1;
      default: count_nxt = buf_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      req_ready <= 1'b0;
      core_run  <= 1'b0;
      core_a    <= '0;
      core_b    <= '0;
      core_op   <= '0;
      tag_q     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            core_a    <= req_a;
            core_b    <= req_b;
            core_op   <= req_op;
            tag_q     <= req_tag;
            core_run  <= 1'b1;
            req_ready <= 1'b0;
            state     <= S_LAUNCH;
          end else begin
            // Registered from next-cycle occupancy, so a pop never opens admission
            // in the same cycle.
            req_ready <= (count_nxt != 2'd2);
          end
        end
        S_LAUNCH: begin
          core_run <= 1'b0;
          cnt      <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (push) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          req_ready <= (count_nxt != 2'd2);
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The entry is written on the WAIT exit edge so the result is the one the core
  // presented when completion was recognised.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        buf_result[i] <= '0;
        buf_flags[i]  <= '0;
        buf_tag[i]    <= '0;
        buf_to[i]     <= 1'b0;
      end
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      buf_count <= '0;
    end else begin
      if (push) begin
        buf_result[wr_ptr] <= timeout_hit ? 32'h7FC0_0000 : core_result;
        buf_flags[wr_ptr]  <= timeout_hit ? 5'b00001 : core_flags;
        buf_tag[wr_ptr]    <= tag_q;
        buf_to[wr_ptr]     <= timeout_hit;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      buf_count <= count_nxt;
    end
  end

  assign rsp_valid   = (buf_count != 2'd0);
  assign rsp_result  = buf_result[rd_ptr];
  assign rsp_flags   = buf_flags[rd_ptr];
  assign rsp_tag     = buf_tag[rd_ptr];
  assign rsp_timeout = buf_to[rd_ptr];
  assign busy        = (state != S_IDLE) || rsp_valid;
  assign dbg_state   = state;

endmodule

// File: tb/tb_fpdsp_issue_seq.sv
// Bench for fpdsp_issue_seq: a behavioural FP-core model, a request driver and a
// response scoreboard checked against a latency-based reference model.
module tb_fpdsp_issue_seq;

  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 64;
  localparam int MIN_LAT = 2;
  localparam int EW      = 32 + 5 + TAG_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic             req_valid, req_ready;
  logic [31:0]      req_a, req_b;
  logic [1:0]       req_op;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      core_a, core_b;
  logic [1:0]       core_op;
  logic             core_run;
  logic [31:0]      core_result;
  logic [4:0]       core_flags;
  logic             core_ready;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_result;
  logic [4:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_timeout;
  logic             busy;
  logic [1:0]       dbg_state;

  fpdsp_issue_seq #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT), .MIN_LAT(MIN_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_tag(req_tag),
    .core_a(core_a), .core_b(core_b), .core_op(core_op), .core_run(core_run),
    .core_result(core_result), .core_flags(core_flags), .core_ready(core_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
    .busy(busy), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  int run_count    = 0;
  int accept_count = 0;
  time last_accept = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [127:0] outs_vec();
    return {16'd0, req_ready, core_a, core_b, core_op, core_run, rsp_valid,
            rsp_result, rsp_flags, rsp_tag, rsp_timeout, busy};
  endfunction

  // Reference: the core's answer comes back unless it arrives later than TIMEOUT
  // cycles after the run pulse, in which case a qNaN/invalid timeout response is due.
  function automatic logic [EW-1:0] model(input logic [TAG_W-1:0] tag, input int lat,
                                          input logic [31:0] val, input logic [4:0] fl,
                                          input bit stale);
    bit to;
    to = !stale && (lat > TIMEOUT);
    return {to ? 32'h7FC0_0000 : val, to ? 5'b00001 : fl, tag, to};
  endfunction

  // ---------------- FP core model ----------------
  logic [31:0] cur_a, cur_b, cur_val;
  logic [1:0]  cur_op;
  logic [4:0]  cur_fl;
  int          cur_lat = 1;
  bit          cur_stale = 0;
  int          rem = 0;
  logic [31:0] pend_val;
  logic [4:0]  pend_fl;
  bit          prev_run = 0;

  always @(negedge clk) begin
    if (rst && core_run) begin
      run_count++;
      check("run_operand_a", core_a, cur_a);
      check("run_operand_b_op", {core_b, core_op}, {cur_b, cur_op});
      check("run_single_pulse", prev_run, 0);
      rem      = cur_lat;
      pend_val = cur_val;
      pend_fl  = cur_fl;
      if (!cur_stale) core_ready = 1'b0;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        core_ready  = 1'b1;
        core_result = pend_val;
        core_flags  = pend_fl;
      end
    end
    prev_run = core_run;
  end

  // ---------------- response monitor / scoreboard ----------------
  logic [EW-1:0] held;
  bit            hold_chk = 0;

  always @(negedge clk) begin
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    got = {rsp_result, rsp_flags, rsp_tag, rsp_timeout};
    if (!rst) begin
      hold_chk = 0;
    end else begin
      if (hold_chk) check("rsp_stable", {rsp_valid, got}, {1'b1, held});
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_extra: got %0h want none", got);
        end else begin
          e = exp_q.pop_front();
          check("rsp", got, e);
        end
        hold_chk = 0;
      end else if (rsp_valid) begin
        held     = got;
        hold_chk = 1;
      end else begin
        hold_chk = 0;
      end
    end
  end

  // ---------------- random downstream readiness ----------------
  bit rand_rdy = 0;
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [TAG_W-1:0] tag, input int lat, input logic [31:0] val,
                       input logic [4:0] fl, input bit stale, input bit expect_rsp);
    int guard;
    guard = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_a = a; req_b = b; req_op = op; req_tag = tag;
    @(negedge clk);
    while (!req_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      fail_now("req_accept");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    cur_a = a; cur_b = b; cur_op = op;
    cur_lat = lat; cur_val = val; cur_fl = fl; cur_stale = stale;
    accept_count++;
    last_accept = $time;
    if (expect_rsp) exp_q.push_back(model(tag, lat, val, fl, stale));
    #1;
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom; req_op = 2'($urandom); req_tag = TAG_W'($urandom);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || busy) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0 || busy) fail_now("drain");
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    int seen;
    bit t3_done;
    time t_a;
    rst = 1'b1;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
    rsp_ready = 1'b0;
    core_ready = 1'b0; core_result = '0; core_flags = '0;
    #1 rst = 1'b0;
    #1 check("reset_outputs_async", outs_vec(), 128'd0);
    repeat (3) @(negedge clk);
    check("reset_outputs_held", outs_vec(), 128'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("req_ready_after_reset", req_ready, 1);

    // single add with latency check
    rsp_ready = 1'b1;
    issue(32'h3F80_0000, 32'h4000_0000, 2'd0, 4'd5, 3, 32'h4040_0000, 5'd0, 0, 1);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("add_rsp_latency", lat, 5);
    drain();
    check("add_run_pulses", run_count, 1);

    // stale ready masking: ready stays high, result changes two cycles after run
    issue(32'h1, 32'h2, 2'd1, 4'd3, 2, 32'h1111_1111, 5'd2, 1, 1);
    issue(32'h3, 32'h4, 2'd2, 4'd4, 2, 32'h2222_2222, 5'd4, 1, 1);
    drain();

    // back-to-back issue period
    issue(32'h5, 32'h6, 2'd3, 4'd7, 1, 32'hAAAA_0001, 5'd0, 0, 1);
    t_a = last_accept;
    issue(32'h7, 32'h8, 2'd0, 4'd8, 1, 32'hAAAA_0002, 5'd1, 0, 1);
    check("b2b_period", (last_accept - t_a) / 10, 4 + MIN_LAT);
    drain();

    // backpressure: third request held off until a pop
    rsp_ready = 1'b0;
    issue(32'h10, 32'h11, 2'd0, 4'd1, 3, 32'hB000_0001, 5'd0, 0, 1);
    issue(32'h12, 32'h13, 2'd1, 4'd2, 3, 32'hB000_0002, 5'd8, 0, 1);
    t3_done = 0;
    fork
      begin
        issue(32'h14, 32'h15, 2'd2, 4'd3, 3, 32'hB000_0003, 5'd16, 0, 1);
        t3_done = 1;
      end
    join_none
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (req_ready) seen++;
    end
    check("bp_req_ready_low", seen, 0);
    check("bp_third_not_accepted", {t3_done, rsp_valid}, {1'b0, 1'b1});
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    lat = 0;
    while (!t3_done && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!t3_done) fail_now("bp_third_accept");
    repeat (10) @(negedge clk);
    rsp_ready = 1'b1;
    drain();

    // watchdog: never-ready core, then boundary latencies
    issue(32'h20, 32'h21, 2'd0, 4'd9, 1000, 32'h0, 5'd0, 0, 1);
    issue(32'h22, 32'h23, 2'd1, 4'd10, 4, 32'hC000_0001, 5'd3, 0, 1);
    issue(32'h24, 32'h25, 2'd2, 4'd11, TIMEOUT, 32'hC000_0002, 5'd5, 0, 1);
    issue(32'h26, 32'h27, 2'd3, 4'd12, TIMEOUT + 1, 32'hC000_0003, 5'd6, 0, 1);
    drain();

    // simultaneous push and pop with one entry held
    rsp_ready = 1'b0;
    issue(32'h30, 32'h31, 2'd0, 4'd6, 3, 32'hD000_0006, 5'd0, 0, 1);
    issue(32'h32, 32'h33, 2'd1, 4'd7, 3, 32'hD000_0007, 5'd9, 0, 1);
    repeat (3) @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pushpop_new_head", {rsp_valid, rsp_tag, rsp_result}, {1'b1, 4'd7, 32'hD000_0007});
    @(negedge clk);
    check("pushpop_no_dup", rsp_valid, 0);
    drain();

    // randomized traffic
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      int r;
      int l;
      bit st;
      r  = $urandom_range(0, 9);
      st = 0;
      if (r < 7)       l = $urandom_range(1, 8);
      else if (r == 7) l = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
      else if (r == 8) l = 300;
      else begin
        l  = $urandom_range(1, MIN_LAT + 1);
        st = 1;
      end
      issue($urandom, $urandom, 2'($urandom), TAG_W'($urandom_range(0, 15)), l,
            $urandom, 5'($urandom), st, 1);
    end
    drain();
    rand_rdy = 0;
    @(posedge clk);
    #2 rsp_ready = 1'b1;

    // asynchronous reset while waiting on the core
    issue(32'h40, 32'h41, 2'd0, 4'd12, 1000, 32'h0, 5'd0, 0, 0);
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1 check("reset_in_wait_outputs", {dbg_state, outs_vec()}, 130'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("req_ready_after_midreset", req_ready, 1);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("no_abandoned_rsp", seen, 0);
    issue(32'h42, 32'h43, 2'd1, 4'd13, 3, 32'hE000_0001, 5'd1, 0, 1);
    drain();

    check("scoreboard_empty", exp_q.size(), 0);
    check("runs_match_accepts", run_count, accept_count);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpdsp_issue_seq.md
Name: fpdsp_issue_seq

Overview:
- Host-side initiator for the iterative FP DSP datapath.
- Accepts operation requests over a valid/ready interface and drives A/B/operation/run into the FP core.
- Waits for the core's ready, then captures result and flags into a 2-entry response buffer.
- Presents responses downstream over valid/ready, in order, with a per-request tag and a timeout watchdog.

Parameters:
TAG_W, 4, width of request/response tag
TIMEOUT, 64, max cycles from run to core ready before a timeout response is forced
MIN_LAT, 2, cycles after run during which core ready is ignored

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid&req_ready
req_a  in  32  operand A (IEEE-754 single)
req_b  in  32  operand B
req_op  in  2  operation code
req_tag  in  TAG_W  request tag
core_a  out  32  operand A to FP core
core_b  out  32  operand B to FP core
core_op  out  2  operation to FP core
core_run  out  1  one-cycle start pulse
core_result  in  32  FP core result
core_flags  in  5  FP core exception flags
core_ready  in  1  FP core done/idle
rsp_valid  out  1  response present
rsp_ready  in  1  downstream accepts when rsp_valid&rsp_ready
rsp_result  out  32  result
rsp_flags  out  5  flags
rsp_tag  out  TAG_W  tag of originating request
rsp_timeout  out  1  response was forced by watchdog
busy  out  1  FSM not IDLE or buffer non-empty

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM=IDLE; all outputs 0; buffer emptied; counters 0.
  - core_a/core_b/core_op are held registers, cleared to 0.
  - Reset mid-operation abandons the in-flight request; no response is produced for it.
- FSM states: IDLE, LAUNCH, WAIT, CAPTURE.
- IDLE:
  - req_ready = (buf_count < 2). A request is accepted only if its response is guaranteed a slot.
  - On accept: latch req_a/b/op/tag into core_a/b/op and an internal tag register; go to LAUNCH.
- LAUNCH:
  - core_run=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
  - req_ready=0 in every state except IDLE.
- WAIT:
  - Counter increments each cycle.
  - core_ready is ignored while counter < MIN_LAT, which masks stale ready from the previous operation.
  - If counter >= MIN_LAT and core_ready=1: go to CAPTURE with timeout=0.
  - Else if counter == TIMEOUT-1: go to CAPTURE with timeout=1.
  - If both conditions hold in the same cycle, core_ready wins (normal capture).
- CAPTURE (one cycle):
  - Write {core_result, core_flags, tag, timeout} into the buffer tail.
  - On timeout, write result=32'h7FC00000 (qNaN) and flags=5'b00001 (invalid) instead of the core values.
  - Go to IDLE.
  - The buffer cannot be full here, because admission was checked in IDLE.
- Response buffer: 2-entry FIFO.
  - rsp_* are driven from the head entry; rsp_valid = (buf_count != 0).
  - Pop on rsp_valid&rsp_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pointers wrap mod 2.
  - Outputs stay stable while rsp_valid&!rsp_ready.
- Admission accounting: buf_count plus the in-flight request must be <= 2.
  - In IDLE nothing is in flight, so buf_count<2 suffices.
  - A pop in the IDLE cycle does not raise req_ready in that same cycle; there is no combinational path from rsp_ready to req_ready.
- Latency:
  - Accept (cycle 0), run (cycle 1).
  - Earliest capture is cycle 1+MIN_LAT+1.
  - rsp_valid rises the cycle after capture.
  - Back-to-back issue: minimum 4+MIN_LAT cycles per request.
- core_a/b/op are held constant from LAUNCH through CAPTURE.

Test Plan:
- Single add: req A=3F800000, B=40000000, op=0, tag=5; core model asserts ready 3 cycles after run with result=40400000, flags=0 -> exactly one core_run pulse; rsp_result=40400000, rsp_tag=5, rsp_timeout=0, rsp_valid rises 5 cycles after accept.
- Stale ready masking: core_ready held 1 continuously, core_result changes 2 cycles after run -> the captured value is the one present at counter=MIN_LAT, never at the LAUNCH cycle.
- Backpressure: rsp_ready=0, issue 3 requests (tags 1,2,3) -> two complete; req_ready stays 0 for tag 3 until one pop; then tag 3 completes and responses drain in order 1,2,3.
- Timeout: core never asserts ready -> after TIMEOUT cycles in WAIT, rsp_result=7FC00000, rsp_flags=00001, rsp_timeout=1; next request proceeds normally.
- Simultaneous push/pop: buffer holds 1 entry with rsp_ready=1 in the CAPTURE cycle -> count stays 1, new head is the captured entry, no loss or duplicate.
- Async reset in WAIT: assert rst=0 mid-WAIT -> all outputs 0 immediately (before the next edge); after release, req_ready=1 and no response for the abandoned tag.
